ufifo_flex: RTL and testbench

- Parametrised single-clock FIFO; next generation of the unit FIFO used on the SPI bridge data paths.
- Full depth is usable: 2^AWIDTH entries.
- Selectable first-word-fall-through (FWFT) or registered-read mode.
- Runtime almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear.

---
 rtl/ufifo_flex.sv | 135 +++++++++++++
 tb/tb_ufifo_flex.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ufifo_flex.sv
// Parametrised single-clock FIFO with selectable first-word-fall-through
// (FWFT=1) or registered-read (FWFT=0) output, all 2^AWIDTH entries usable.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_wr, i_data                   write request and data
//   i_rd                           read request (FWFT=1: pop head, FWFT=0: fetch head)
//   o_data, o_valid                read data and its qualifier
//   i_af_thresh, i_ae_thresh       runtime almost-full / almost-empty thresholds
//   i_err_clr                      clears sticky overflow/underflow flags
//   o_fill, o_full, o_empty        stored entry count and its registered flags
//   o_almost_full, o_almost_empty  live compares of o_fill against the thresholds
//   o_overflow, o_underflow        sticky rejected-write / rejected-read flags
module ufifo_flex #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned AWIDTH = 2,
    parameter int unsigned FWFT   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_rd,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_valid,
    input  logic [AWIDTH:0]   i_af_thresh,
    input  logic [AWIDTH:0]   i_ae_thresh,
    input  logic              i_err_clr,
    output logic [AWIDTH:0]   o_fill,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned PW    = AWIDTH + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    fill_next;
    logic             w_read;
    logic             w_write;

    // Reads never bypass a same-cycle write; writes to a full FIFO need a paired read.
    assign w_read  = i_rd && !o_empty;
    assign w_write = i_wr && (!o_full || w_read);

    // Next occupancy; simultaneous read and write leave it unchanged.
    always_comb begin
        fill_next = o_fill;
        if (w_write && !w_read) begin
            fill_next = o_fill + PW'(1);
        end else if (w_read && !w_write) begin
            fill_next = o_fill - PW'(1);
        end
    end

    // Pointers, occupancy and full/empty flags, all derived from fill_next.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_fill  <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (w_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (w_read) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            o_fill  <= fill_next;
            o_full  <= (fill_next == PW'(DEPTH));
            o_empty <= (fill_next == '0);
        end
    end

    // Storage array; contents are not reset, pointers make them unreachable.
    always_ff @(posedge i_clk) begin
        if (w_write && !i_reset) begin
            mem[wr_ptr[AWIDTH-1:0]] <= i_data;
        end
    end

    // Sticky error flags; a new error in the clear cycle wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr && !w_write) begin
                o_overflow <= 1'b1;
            end else if (i_err_clr) begin
                o_overflow <= 1'b0;
            end
            if (i_rd && !w_read) begin
                o_underflow <= 1'b1;
            end else if (i_err_clr) begin
                o_underflow <= 1'b0;
            end
        end
    end

    // Thresholds are compared live; values above DEPTH naturally pin the flags.
    assign o_almost_full  = (o_fill >= i_af_thresh);
    assign o_almost_empty = (o_fill <= i_ae_thresh);

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly from the array.
            always_comb begin
                o_data  = mem[rd_ptr[AWIDTH-1:0]];
                o_valid = !o_empty;
            end
        end else begin : g_reg
            // Registered read: the array read sees the pre-write word on address collision.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    o_data  <= '0;
                    o_valid <= 1'b0;
                end else begin
                    o_valid <= w_read;
                    if (w_read) begin
                        o_data <= mem[rd_ptr[AWIDTH-1:0]];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ufifo_flex.sv
module tb_ufifo_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = '0;
    logic       rd = 1'b0;
    logic [2:0] af = 3'd4;
    logic [2:0] ae = 3'd0;
    logic       clr = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic [2:0] a_fill, b_fill;
    logic       a_full, b_full, a_empty, b_empty;
    logic       a_af, b_af, a_ae, b_ae;
    logic       a_ovf, b_ovf, a_unf, b_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ufifo_flex #(.WIDTH(8), .AWIDTH(2), .FWFT(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .i_rd(rd),
        .o_data(a_data), .o_valid(a_valid), .i_af_thresh(af), .i_ae_thresh(ae),
        .i_err_clr(clr), .o_fill(a_fill), .o_full(a_full), .o_empty(a_empty),
        .o_almost_full(a_af), .o_almost_empty(a_ae),
        .o_overflow(a_ovf), .o_underflow(a_unf)
    );

    ufifo_flex #(.WIDTH(8), .AWIDTH(2), .FWFT(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .i_rd(rd),
        .o_data(b_data), .o_valid(b_valid), .i_af_thresh(af), .i_ae_thresh(ae),
        .i_err_clr(clr), .o_fill(b_fill), .o_full(b_full), .o_empty(b_empty),
        .o_almost_full(b_af), .o_almost_empty(b_ae),
        .o_overflow(b_ovf), .o_underflow(b_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] wvals [4];
    logic [7:0] dvals [4];

    initial begin
        wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33; wvals[3] = 8'h44;
        dvals[0] = 8'h22; dvals[1] = 8'h33; dvals[2] = 8'h44; dvals[3] = 8'h55;

        // Reset state
        do_reset();
        chk("rst_fill", a_fill, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_valid_a", a_valid, 0);
        chk("rst_valid_b", b_valid, 0);
        chk("rst_data_b", b_data, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af_t4", a_af, 0);
        af = 3'd0; #1;
        chk("rst_af_t0", a_af, 1);
        af = 3'd4; #1;

        // 1: fill to full in FWFT mode
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; din = wvals[i];
            tick();
            chk("t1_fill", a_fill, 32'(i + 1));
            chk("t1_head", a_data, 8'h11);
            chk("t1_valid", a_valid, 1);
        end
        wr = 1'b0;
        chk("t1_full", a_full, 1);
        chk("t1_ovf", a_ovf, 0);

        // 2: overflow, then write-with-read while full
        wr = 1'b1; din = 8'h55;
        tick();
        chk("t2_ovf", a_ovf, 1);
        chk("t2_fill", a_fill, 4);
        rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("t2_fill_rw", a_fill, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain", a_data, 32'(dvals[i]));
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        chk("t2_empty", a_empty, 1);
        chk("t2_fill0", a_fill, 0);

        // 3: underflow with simultaneous write, then clear behaviour
        rd = 1'b1; wr = 1'b1; din = 8'h66;
        tick();
        rd = 1'b0; wr = 1'b0;
        chk("t3_unf", a_unf, 1);
        chk("t3_fill", a_fill, 1);
        chk("t3_data", a_data, 8'h66);
        chk("t3_valid", a_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clr_ovf", a_ovf, 0);
        chk("t3_clr_unf", a_unf, 0);
        rd = 1'b1;
        tick();
        chk("t3_pop_empty", a_empty, 1);
        clr = 1'b1;
        tick();
        rd = 1'b0;
        chk("t3_set_wins", a_unf, 1);
        tick();
        clr = 1'b0;
        chk("t3_clr2", a_unf, 0);

        // 4: registered-read mode
        do_reset();
        wr = 1'b1; din = 8'hA1; tick();
        din = 8'hA2; tick();
        wr = 1'b0;
        chk("t4_idle_valid", b_valid, 0);
        chk("t4_idle_data", b_data, 0);
        rd = 1'b1; tick();
        chk("t4_valid1", b_valid, 1);
        chk("t4_data1", b_data, 8'hA1);
        tick();
        rd = 1'b0;
        chk("t4_valid2", b_valid, 1);
        chk("t4_data2", b_data, 8'hA2);
        tick();
        chk("t4_valid_lo", b_valid, 0);
        chk("t4_hold", b_data, 8'hA2);
        chk("t4_fill", b_fill, 0);
        // full with read and write colliding on one address: old word returned
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'(8'hB0 + i);
            tick();
        end
        chk("t4_full", b_full, 1);
        din = 8'hC0; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("t4_coll_data", b_data, 8'hB0);
        chk("t4_coll_fill", b_fill, 4);

        // 5: almost thresholds
        do_reset();
        af = 3'd3; ae = 3'd1;
        for (int k = 0; k <= 4; k++) begin
            #1;
            chk("t5_ae", a_ae, (k <= 1) ? 1 : 0);
            chk("t5_af", a_af, (k >= 3) ? 1 : 0);
            if (k == 2) begin
                af = 3'd2; #1;
                chk("t5_af_live", a_af, 1);
                af = 3'd3; #1;
            end
            if (k < 4) begin
                wr = 1'b1; din = 8'(k);
                tick();
                wr = 1'b0;
            end
        end
        af = 3'd7; ae = 3'd5; #1;
        chk("t5_af_big", a_af, 0);
        chk("t5_ae_big", a_ae, 1);
        af = 3'd4; ae = 3'd0;

        // 6: wrap-around with order check, then reset mid-operation
        do_reset();
        wr = 1'b1;
        din = 8'h80; tick();
        din = 8'h81; tick();
        rd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("t6_order", a_data, 32'(8'h80 + i));
            din = 8'(8'h82 + i);
            tick();
            chk("t6_fill", a_fill, 2);
        end
        rd = 1'b0;
        din = 8'hEE; tick();
        chk("t6_fill3", a_fill, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0; wr = 1'b0;
        chk("t6_rst_fill", a_fill, 0);
        chk("t6_rst_empty", a_empty, 1);
        chk("t6_rst_valid_a", a_valid, 0);
        chk("t6_rst_valid_b", b_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
